// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-channel valid/ready multiplexer with a single registered output
// stage. Channels are picked either by a fixed select or by round-robin
// arbitration, and one word per cycle can flow while the consumer is ready.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   in_data    : flat input bus, channel i at [i*WIDTH +: WIDTH]
//   in_vld     : per-channel valid
//   in_rdy     : per-channel ready (combinational, at most one bit high)
//   s          : fixed channel select, used when mode = 0
//   mode       : 0 = fixed select, 1 = round-robin
//   y          : registered output data
//   y_vld      : output valid
//   y_rdy      : consumer ready
//   y_ch       : channel index that produced the current y
module mux_nx1_rr #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_vld,
    output logic [N-1:0]         in_rdy,
    input  logic [SELW-1:0]      s,
    input  logic                 mode,
    output logic [WIDTH-1:0]     y,
    output logic                 y_vld,
    input  logic                 y_rdy,
    output logic [SELW-1:0]      y_ch
);

    logic [WIDTH-1:0] y_q,     y_d;
    logic             y_vld_q, y_vld_d;
    logic [SELW-1:0]  y_ch_q,  y_ch_d;
    logic [SELW-1:0]  ptr_q,   ptr_d;

    logic [WIDTH-1:0] ch_data [N];
    logic             s_in_range;
    logic             fx_found;
    logic             rr_found;
    logic [SELW-1:0]  rr_g;
    int unsigned      rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic             out_free;
    logic             accept;
    logic [N-1:0]     in_rdy_c;

    // Unpack the flat input bus into per-channel words.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // A select value >= N can only exist when N is not a power of two.
    if ((1 << SELW) == N) begin : g_sel_full
        assign s_in_range = 1'b1;
    end else begin : g_sel_partial
        assign s_in_range = (s < SELW'(N));
    end

    assign fx_found = s_in_range & in_vld[s];

    // Round-robin scan starting at ptr, wrapping through N-1 back to ptr-1.
    always_comb begin
        rr_found = 1'b0;
        rr_g     = '0;
        rr_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            rr_idx = (32'(ptr_q) + k) % N;
            if (!rr_found && in_vld[SELW'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_g     = SELW'(rr_idx);
            end
        end
    end

    assign grant_vld = mode ? rr_found : fx_found;
    assign grant     = mode ? rr_g     : s;
    assign out_free  = ~y_vld_q | y_rdy;
    assign accept    = grant_vld & out_free;

    // Ready goes only to the granted channel, and never while in reset.
    always_comb begin
        in_rdy_c = '0;
        if (rst_n && accept) begin
            in_rdy_c[grant] = 1'b1;
        end
    end

    assign in_rdy = in_rdy_c;

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        y_d     = y_q;
        y_vld_d = y_vld_q;
        y_ch_d  = y_ch_q;
        ptr_d   = ptr_q;
        if (accept) begin
            y_d     = ch_data[grant];
            y_ch_d  = grant;
            y_vld_d = 1'b1;
            if (mode) begin
                ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
            end
        end else if (y_rdy) begin
            y_vld_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_vld_q <= 1'b0;
            y_ch_q  <= '0;
            ptr_q   <= '0;
        end else begin
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            y_ch_q  <= y_ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;
    assign y_ch  = y_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed scenarios plus randomized traffic for mux_nx1_rr,
// compared against a transaction-level reference model.
module tb_mux_nx1_rr;

    localparam int unsigned W    = 8;
    localparam int unsigned N    = 4;
    localparam int unsigned SELW = $clog2(N);

    logic               clk;
    logic               rst_n;
    logic [N*W-1:0]     in_data;
    logic [N-1:0]       in_vld;
    logic [N-1:0]       in_rdy;
    logic [SELW-1:0]    s;
    logic               mode;
    logic [W-1:0]       y;
    logic               y_vld;
    logic               y_rdy;
    logic [SELW-1:0]    y_ch;

    int n_checks;
    int n_errors;

    // Reference model state.
    int         m_ptr;
    logic [W-1:0] m_y;
    bit         m_vld;
    int         m_ch;

    mux_nx1_rr #(.WIDTH(W), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .s       (s),
        .mode    (mode),
        .y       (y),
        .y_vld   (y_vld),
        .y_rdy   (y_rdy),
        .y_ch    (y_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chan(input int i);
        logic [N*W-1:0] d;
        d = in_data;
        return d[i*W +: W];
    endfunction

    // Which channel the rules say is granted now; -1 for none.
    function automatic int model_grant();
        if (!mode) begin
            if (int'(s) < N && in_vld[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (in_vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_vld || y_rdy)) return N'(1) << g;
        return '0;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_y   = '0;
        m_vld = 0;
        m_ch  = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_y"},     32'(y),     32'(m_y));
        chk({tag, "_y_vld"}, 32'(y_vld), 32'(m_vld));
        chk({tag, "_y_ch"},  32'(y_ch),  32'(m_ch));
    endtask

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic cycle(input string tag);
        int g;
        bit free;
        #1;
        chk({tag, "_in_rdy"}, 32'(in_rdy), 32'(model_rdy()));
        g    = model_grant();
        free = !m_vld || y_rdy;
        @(posedge clk);
        if (g >= 0 && free) begin
            m_y   = chan(g);
            m_ch  = g;
            m_vld = 1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (y_rdy) begin
            m_vld = 0;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_chan(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n   = 1'b0;
        in_data = '0;
        in_vld  = 4'b1111;
        s       = '0;
        mode    = 1'b0;
        y_rdy   = 1'b1;

        // 1. Reset / idle.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'(0));
        check_outputs("rst");
        @(negedge clk);
        in_vld = '0;
        rst_n  = 1'b1;
        repeat (2) cycle("idle");
        chk("idle_vld", 32'(y_vld), 32'(0));

        // 2. Fixed select.
        mode = 1'b0;
        s    = 2'd2;
        set_chan(2, 8'hA5);
        in_vld = 4'b0100;
        #1;
        chk("fix_rdy", 32'(in_rdy), 32'(4'b0100));
        cycle("fix");
        chk("fix_y", 32'(y), 32'(8'hA5));
        chk("fix_ch", 32'(y_ch), 32'(2));
        s = 2'd3;
        cycle("fix_nogrant");
        chk("fix_nogrant_vld", 32'(y_vld), 32'(0));

        // 3. Round-robin fairness.
        mode = 1'b1;
        for (int i = 0; i < N; i++) set_chan(i, 8'(8'h10 + i));
        in_vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("rr_all");
            chk("rr_seq", 32'(y), 32'(8'h10 + (i % N)));
        end
        in_vld = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cycle("rr_1001");
            chk("rr_alt", 32'(y_ch), (i % 2 == 0) ? 32'd3 : 32'd0);
        end

        // 4. Back-pressure.
        set_chan(1, 8'h3C);
        in_vld = 4'b0010;
        cycle("bp_first");
        chk("bp_first_y", 32'(y), 32'(8'h3C));
        y_rdy  = 1'b0;
        in_vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold");
            chk("bp_hold_y", 32'(y), 32'(8'h3C));
            chk("bp_hold_rdy", 32'(in_rdy), 32'(0));
        end
        y_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_rdy), 32'(4'b0100));
        cycle("bp_release");
        chk("bp_release_ch", 32'(y_ch), 32'(2));

        // 5. Pointer wrap.
        in_vld = 4'b0100;
        cycle("wrap_a");
        in_vld = 4'b0001;
        cycle("wrap_b");
        chk("wrap_ch0", 32'(y_ch), 32'(0));
        in_vld = 4'b1000;
        cycle("wrap_c");
        chk("wrap_ch3", 32'(y_ch), 32'(3));
        in_vld = 4'b1111;
        cycle("wrap_d");
        chk("wrap_ptr0", 32'(y_ch), 32'(0));

        // 6. Asynchronous reset with a word held under back-pressure.
        y_rdy = 1'b0;
        cycle("mid_hold");
        chk("mid_hold_vld", 32'(y_vld), 32'(1));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_vld", 32'(y_vld), 32'(0));
        chk("mid_rst_y", 32'(y), 32'(0));
        chk("mid_rst_rdy", 32'(in_rdy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        y_rdy = 1'b1;
        in_vld = 4'b1111;
        cycle("mid_restart");
        chk("mid_restart_ch", 32'(y_ch), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_data = {$urandom, $urandom};
            in_vld  = N'($urandom);
            s       = SELW'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            y_rdy   = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
